phantom_rtc: RTL

PHANTOM_RTC -- requirements
Module: phantom_rtc

---
 rtl/phantom_rtc.sv | 100 ++++++++++
 1 files changed

// File: rtl/phantom_rtc.sv
// phantom_rtc: phantom real-time clock unlocked by a 64-access A0 read pattern on the ROM chip select
module phantom_rtc #(
  parameter int PRESCALE = 71590
) (
  input  logic C7M,
  input  logic RES,
  input  logic nRAMROMCS,
  input  logic nWE,
  input  logic A0,
  input  logic D0,
  output logic RAMROMCSgb,
  output logic Q,
  output logic QOE
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [63:0] PAT = 64'h5CA33AC5_5CA33AC5;
  localparam logic [63:0] MASK = 64'hFF1F3F07_3FFFFFFF;
  localparam logic [63:0] TM_RST = 64'h00010101_00000000;
  typedef enum logic {MATCH, XFER} state_t;
  state_t state, state_nx;
  logic cs_r, cs_p, a0_c, we_c, d0_c, sess_wr, acc_end, hit, first, contrary, done, commit, tick, leap, c;
  logic [1:0] st_d, lm;
  logic [5:0] idx;
  logic [PW-1:0] pre;
  logic [7:0] mlen;
  logic [63:0] snap, shadow, wdata, tm, tm_nx, lim;
  function automatic logic [7:0] inc(input logic [7:0] x);
    return x[3:0] == 4'h9 ? {x[7:4] + 4'h1, 4'h0} : x + 8'h1;
  endfunction
  always_ff @(posedge C7M) begin
    cs_r <= nRAMROMCS;
    cs_p <= cs_r;
    st_d <= {st_d[0], cs_p & ~cs_r};
    if (st_d[1]) {a0_c, we_c, d0_c} <= {A0, nWE, D0};
  end
  assign acc_end = ~cs_p & cs_r;
  assign first = idx == 6'd0;
  assign hit = we_c && a0_c == PAT[idx];
  assign contrary = state == XFER && !first && we_c == sess_wr;
  assign done = idx == 6'd63 && (state == XFER ? !contrary : hit);
  assign commit = acc_end && state == XFER && done && sess_wr;
  assign tick = pre == PMAX;
  always_comb begin
    wdata = shadow;
    wdata[idx] = d0_c;
  end
  always_ff @(posedge C7M) begin
    if (RES) state <= MATCH;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = !acc_end ? state : state == MATCH ? (done ? XFER : MATCH) : (contrary || done ? MATCH : XFER);
  end
  always_comb begin
    RAMROMCSgb = nRAMROMCS | (state == XFER && !RES);
    Q = state == XFER && !RES && snap[idx];
    QOE = state == XFER && !RES && !nRAMROMCS && nWE;
  end
  // the index wraps 63->0 by itself, so a completed match or transfer restarts at 0
  always_ff @(posedge C7M) begin
    if (RES) begin
      idx <= 6'd0;
      sess_wr <= 1'b0;
      snap <= '0;
      shadow <= '0;
    end else if (acc_end) begin
      idx <= (state == MATCH ? hit : !contrary) ? idx + 6'd1 : 6'd0;
      if (state == MATCH && done) snap <= tm;
      if (state == XFER && first) sess_wr <= !we_c;
      if (state == XFER && !we_c && !contrary) shadow <= wdata;
    end
  end
  assign lm = tm[57:56] + {tm[60], 1'b0};
  assign leap = lm == 2'd0;
  assign mlen = tm[55:48] == 8'h02 ? (leap ? 8'h29 : 8'h28) :
                (tm[55:48] == 8'h04 || tm[55:48] == 8'h06 || tm[55:48] == 8'h09 || tm[55:48] == 8'h11) ? 8'h30 : 8'h31;
  assign lim = {8'h99, 8'h12, mlen, 8'h07, 8'h23, 8'h59, 8'h59, 8'h99};
  // day of week rolls on the hour carry but does not feed the date carry
  always_comb begin
    c = 1'b1;
    tm_nx = tm;
    for (int i = 0; i < 8; i++) begin
      if (c) tm_nx[i*8 +: 8] = tm[i*8 +: 8] == lim[i*8 +: 8] ? TM_RST[i*8 +: 8] : inc(tm[i*8 +: 8]);
      if (i != 4) c = c && tm[i*8 +: 8] == lim[i*8 +: 8];
    end
  end
  always_ff @(posedge C7M) begin
    if (RES) begin
      tm <= TM_RST;
      pre <= '0;
    end else if (commit) begin
      tm <= wdata & MASK;
      pre <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) tm <= tm_nx;
    end
  end
endmodule
